vram_arb: RTL and testbench

Arbiter and sequencer for the single-port 16x64K VRAM. It shares the VRAM among three requesters:
- the video generator, with absolute priority and no wait states;
- the host-register path;
- the blitter engine.

The two lower-priority requesters share the remaining cycles round-robin, each through a req/ack handshake. The block also tracks worst-case wait latency for tuning. It sits between the requesters and the `vram` instance, replacing the ad-hoc vgen/blitter mux in `xosera_main`.

---
 rtl/vram_arb_pkg.sv | 15 +
 rtl/vram_arb_stall.sv | 46 ++++
 rtl/vram_arb.sv | 128 ++++++++++++
 tb/tb_vram_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Package xv: shared types and constants for the VRAM arbiter.
//   arb_owner_t      - owner tag for a VRAM cycle (none / video / host / blitter)
//   ARB_STALL_W_DEF  - default width of the saturating wait-latency counters
package xv;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_VGEN = 2'd1,
    ARB_HOST = 2'd2,
    ARB_BLIT = 2'd3
  } arb_owner_t;

  localparam int ARB_STALL_W_DEF = 8;

endpackage

// File: rtl/vram_arb_stall.sv
// vram_arb_stall: wait-latency tracker for one req/ack requester.
// Counts cycles spent waiting (req=1, ack=0), saturating at all-ones, and
// keeps the largest wait seen at ack time.
// Ports:
//   clk, reset_i  - clock, synchronous active-high reset
//   req, ack      - requester handshake being observed
//   clear         - zero the stored maximum (wins over a same-cycle ack)
//   max_o         - longest wait since reset/clear
module vram_arb_stall
  import xv::*;
#(
  parameter int STALL_W = ARB_STALL_W_DEF
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               req,
  input  logic               ack,
  input  logic               clear,
  output logic [STALL_W-1:0] max_o
);

  logic [STALL_W-1:0] r_cnt;
  logic [STALL_W-1:0] r_max;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Wait counter / maximum register
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_cnt <= '0;
      r_max <= '0;
    end else begin
      // A dropped request ends the wait without producing a sample.
      if (ack || !req) r_cnt <= '0;
      else             r_cnt <= sat_inc(r_cnt);

      if (clear)                     r_max <= '0;
      else if (ack && r_cnt > r_max) r_max <= r_cnt;
    end
  end

  assign max_o = r_max;

endmodule

// File: rtl/vram_arb.sv
// vram_arb: arbiter/sequencer for the single-port 16x64K VRAM.
// Video generator has absolute priority; host and blitter share the
// remaining cycles round-robin through req/ack handshakes.
// Ports:
//   clk, reset_i                         - pixel clock, sync active-high reset
//   vgen_sel_i, vgen_addr_i              - video read request (always served)
//   host_* / blit_*                      - req, wr, addr, data in; ack, rd_valid out
//   rd_data_o                            - VRAM read data, shared by all
//   vram_sel_o/wr_o/addr_o/data_o        - VRAM control, combinational
//   vram_data_i                          - VRAM read data, 1-cycle latency
//   stall_host_o, stall_blit_o           - saturating worst-case wait
//   clear_stats_i                        - zero both wait maxima
module vram_arb
  import xv::*;
#(
  parameter int STALL_W = ARB_STALL_W_DEF
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               vgen_sel_i,
  input  logic [15:0]        vgen_addr_i,
  input  logic               host_req_i,
  input  logic               host_wr_i,
  input  logic [15:0]        host_addr_i,
  input  logic [15:0]        host_data_i,
  output logic               host_ack_o,
  output logic               host_rd_valid_o,
  input  logic               blit_req_i,
  input  logic               blit_wr_i,
  input  logic [15:0]        blit_addr_i,
  input  logic [15:0]        blit_data_i,
  output logic               blit_ack_o,
  output logic               blit_rd_valid_o,
  output logic [15:0]        rd_data_o,
  output logic               vram_sel_o,
  output logic               vram_wr_o,
  output logic [15:0]        vram_addr_o,
  output logic [15:0]        vram_data_o,
  input  logic [15:0]        vram_data_i,
  output logic [STALL_W-1:0] stall_host_o,
  output logic [STALL_W-1:0] stall_blit_o,
  input  logic               clear_stats_i
);

  arb_owner_t r_rr;
  arb_owner_t r_rd_owner_p1;
  arb_owner_t w_rd_owner_p0;
  logic       w_host_grant;
  logic       w_blit_grant;

  // Stage p0: grant decision and VRAM mux (combinational)
  always_comb begin
    w_host_grant = 1'b0;
    w_blit_grant = 1'b0;
    if (!reset_i && !vgen_sel_i) begin
      if (host_req_i && (!blit_req_i || r_rr == ARB_HOST)) w_host_grant = 1'b1;
      else if (blit_req_i)                                 w_blit_grant = 1'b1;
    end
  end

  always_comb begin
    vram_sel_o  = 1'b0;
    vram_wr_o   = 1'b0;
    vram_addr_o = '0;
    vram_data_o = '0;
    // vgen is deliberately not gated by reset: the display keeps running.
    if (vgen_sel_i) begin
      vram_sel_o  = 1'b1;
      vram_addr_o = vgen_addr_i;
    end else if (w_host_grant) begin
      vram_sel_o  = 1'b1;
      vram_wr_o   = host_wr_i;
      vram_addr_o = host_addr_i;
      vram_data_o = host_data_i;
    end else if (w_blit_grant) begin
      vram_sel_o  = 1'b1;
      vram_wr_o   = blit_wr_i;
      vram_addr_o = blit_addr_i;
      vram_data_o = blit_data_i;
    end
  end

  always_comb begin
    w_rd_owner_p0 = ARB_NONE;
    if (vgen_sel_i)                     w_rd_owner_p0 = ARB_VGEN;
    else if (w_host_grant && !host_wr_i) w_rd_owner_p0 = ARB_HOST;
    else if (w_blit_grant && !blit_wr_i) w_rd_owner_p0 = ARB_BLIT;
  end

  assign host_ack_o = w_host_grant;
  assign blit_ack_o = w_blit_grant;

  // Stage p0 -> p1: round-robin pointer and read-owner tag
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_rr          <= ARB_HOST;
      r_rd_owner_p1 <= ARB_NONE;
    end else begin
      if (w_host_grant)      r_rr <= ARB_BLIT;
      else if (w_blit_grant) r_rr <= ARB_HOST;
      r_rd_owner_p1 <= w_rd_owner_p0;
    end
  end

  // Stage p1: read return; reset masks a read granted just before it
  assign host_rd_valid_o = !reset_i && (r_rd_owner_p1 == ARB_HOST);
  assign blit_rd_valid_o = !reset_i && (r_rd_owner_p1 == ARB_BLIT);
  assign rd_data_o       = vram_data_i;

  vram_arb_stall #(.STALL_W(STALL_W)) u_stall_host (
    .clk     (clk),
    .reset_i (reset_i),
    .req     (host_req_i),
    .ack     (w_host_grant),
    .clear   (clear_stats_i),
    .max_o   (stall_host_o)
  );

  vram_arb_stall #(.STALL_W(STALL_W)) u_stall_blit (
    .clk     (clk),
    .reset_i (reset_i),
    .req     (blit_req_i),
    .ack     (w_blit_grant),
    .clear   (clear_stats_i),
    .max_o   (stall_blit_o)
  );

endmodule

// File: tb/tb_vram_arb.sv
module tb_vram_arb;
  import xv::*;

  localparam int SW  = 3;
  localparam int CAP = (1 << SW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i;
  logic          vgen_sel_i;
  logic [15:0]   vgen_addr_i;
  logic          host_req_i, host_wr_i;
  logic [15:0]   host_addr_i, host_data_i;
  logic          host_ack_o, host_rd_valid_o;
  logic          blit_req_i, blit_wr_i;
  logic [15:0]   blit_addr_i, blit_data_i;
  logic          blit_ack_o, blit_rd_valid_o;
  logic [15:0]   rd_data_o;
  logic          vram_sel_o, vram_wr_o;
  logic [15:0]   vram_addr_o, vram_data_o;
  logic [15:0]   vram_data_i;
  logic [SW-1:0] stall_host_o, stall_blit_o;
  logic          clear_stats_i;

  vram_arb #(.STALL_W(SW)) dut (
    .clk(clk), .reset_i(reset_i),
    .vgen_sel_i(vgen_sel_i), .vgen_addr_i(vgen_addr_i),
    .host_req_i(host_req_i), .host_wr_i(host_wr_i), .host_addr_i(host_addr_i),
    .host_data_i(host_data_i), .host_ack_o(host_ack_o), .host_rd_valid_o(host_rd_valid_o),
    .blit_req_i(blit_req_i), .blit_wr_i(blit_wr_i), .blit_addr_i(blit_addr_i),
    .blit_data_i(blit_data_i), .blit_ack_o(blit_ack_o), .blit_rd_valid_o(blit_rd_valid_o),
    .rd_data_o(rd_data_o),
    .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_addr_o(vram_addr_o),
    .vram_data_o(vram_data_o), .vram_data_i(vram_data_i),
    .stall_host_o(stall_host_o), .stall_blit_o(stall_blit_o),
    .clear_stats_i(clear_stats_i)
  );

  // VRAM device model: driven only by the DUT's VRAM port.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (vram_sel_o) begin
      if (vram_wr_o) mem[vram_addr_o] <= vram_data_o;
      vram_data_i <= mem[vram_addr_o];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model state
  typedef struct {
    int          cyc;
    arb_owner_t  who;
    logic [15:0] data;
  } rd_exp_t;
  rd_exp_t     q[$];
  logic [15:0] ref_mem [0:65535];
  int          m_last_blit;  // 1 when blitter was served last (host is next in a tie)
  int          m_wait_h, m_wait_b, m_max_h, m_max_b;
  logic        d_hack, d_back;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int capped(input int v);
    return (v > CAP) ? CAP : v;
  endfunction

  task automatic stall_upd(input logic req, input logic ack, inout int w, inout int mx);
    if (ack) begin
      if (!clear_stats_i && w > mx) mx = w;
      w = 0;
    end else if (req) w++;
    else w = 0;
    if (clear_stats_i) mx = 0;
  endtask

  // Called just after a falling edge with this cycle's inputs applied.
  task automatic step(output logic eh, output logic eb);
    logic        es, ew;
    logic [15:0] ea, ed;
    #1;
    chk("stall_host", 32'(stall_host_o), capped(m_max_h));
    chk("stall_blit", 32'(stall_blit_o), capped(m_max_b));
    eh = 1'b0;
    eb = 1'b0;
    if (!reset_i && !vgen_sel_i) begin
      if (host_req_i && blit_req_i) begin
        if (m_last_blit == 1) eh = 1'b1; else eb = 1'b1;
      end else if (host_req_i) eh = 1'b1;
      else if (blit_req_i)     eb = 1'b1;
    end
    d_hack = host_ack_o;
    d_back = blit_ack_o;
    chk("host_ack", host_ack_o, eh);
    chk("blit_ack", blit_ack_o, eb);
    es = vgen_sel_i | eh | eb;
    ew = eh ? host_wr_i : (eb ? blit_wr_i : 1'b0);
    ea = vgen_sel_i ? vgen_addr_i : (eh ? host_addr_i : (eb ? blit_addr_i : 16'h0));
    ed = eh ? host_data_i : (eb ? blit_data_i : 16'h0);
    chk("vram_sel", vram_sel_o, es);
    chk("vram_wr", vram_wr_o, ew);
    chk("vram_addr", vram_addr_o, ea);
    if (!vgen_sel_i) chk("vram_data", vram_data_o, ed);
    if (eh) begin
      if (host_wr_i) ref_mem[host_addr_i] = host_data_i;
      else q.push_back('{cyc, ARB_HOST, ref_mem[host_addr_i]});
    end
    if (eb) begin
      if (blit_wr_i) ref_mem[blit_addr_i] = blit_data_i;
      else q.push_back('{cyc, ARB_BLIT, ref_mem[blit_addr_i]});
    end
    if (reset_i) begin
      m_last_blit = 1;
      m_wait_h = 0; m_wait_b = 0; m_max_h = 0; m_max_b = 0;
    end else begin
      stall_upd(host_req_i, eh, m_wait_h, m_max_h);
      stall_upd(blit_req_i, eb, m_wait_b, m_max_b);
      if (eh) m_last_blit = 0;
      else if (eb) m_last_blit = 1;
    end
    @(negedge clk);
  endtask

  // Monitor: read returns are popped and compared one cycle after the grant.
  initial begin
    rd_exp_t     e;
    logic        vh, vb;
    logic [15:0] vd;
    forever begin
      @(negedge clk);
      #2;
      vh = 1'b0; vb = 1'b0; vd = 16'h0;
      if (q.size() > 0 && q[0].cyc == cyc - 1) begin
        e = q.pop_front();
        if (!reset_i) begin
          vh = (e.who == ARB_HOST);
          vb = (e.who == ARB_BLIT);
          vd = e.data;
        end
      end
      chk("host_rd_valid", host_rd_valid_o, vh);
      chk("blit_rd_valid", blit_rd_valid_o, vb);
      if (vh || vb) chk("rd_data", rd_data_o, vd);
    end
  end

  task automatic idle_inputs();
    vgen_sel_i = 0; vgen_addr_i = 0; clear_stats_i = 0;
    host_req_i = 0; host_wr_i = 0; host_addr_i = 0; host_data_i = 0;
    blit_req_i = 0; blit_wr_i = 0; blit_addr_i = 0; blit_data_i = 0;
  endtask

  initial begin
    logic eh, eb, ha, ba;
    int   hc, bc;
    reset_i = 1'b1;
    idle_inputs();
    m_last_blit = 1;
    m_wait_h = 0; m_wait_b = 0; m_max_h = 0; m_max_b = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     <= 16'(i) ^ 16'h5A5A;
      ref_mem[i]  = 16'(i) ^ 16'h5A5A;
    end
    mem[16'h1234]     <= 16'hBEEF;
    ref_mem[16'h1234]  = 16'hBEEF;

    @(negedge clk);
    host_req_i = 1;  // acks must stay low during reset
    step(eh, eb);
    step(eh, eb);
    reset_i = 0;
    idle_inputs();
    step(eh, eb);

    // Lone host read of 0x1234
    host_req_i = 1; host_wr_i = 0; host_addr_i = 16'h1234;
    step(eh, eb);
    host_req_i = 0;
    step(eh, eb);

    // Continuous contention after reset: H,B,H,B...
    reset_i = 1; step(eh, eb); reset_i = 0;
    host_req_i = 1; host_addr_i = 16'h0100;
    blit_req_i = 1; blit_addr_i = 16'h0200;
    hc = 0; bc = 0;
    for (int i = 0; i < 8; i++) begin
      step(eh, eb);
      if (d_hack) begin hc++; host_addr_i++; end
      if (d_back) begin bc++; blit_addr_i++; end
    end
    chk("share_host", hc, 4);
    chk("share_blit", bc, 4);
    idle_inputs();
    step(eh, eb);

    // vgen burst of 5 while host waits
    host_req_i = 1; host_addr_i = 16'h0020;
    for (int i = 0; i < 5; i++) begin
      vgen_sel_i = 1; vgen_addr_i = 16'h8000 + 16'(i);
      step(eh, eb);
    end
    vgen_sel_i = 0;
    step(eh, eb);
    host_req_i = 0;
    step(eh, eb);
    chk("stall_host_5", 32'(stall_host_o), 5);

    // Blit write then host read-back
    blit_req_i = 1; blit_wr_i = 1; blit_addr_i = 16'h0010; blit_data_i = 16'hA5A5;
    step(eh, eb);
    idle_inputs();
    host_req_i = 1; host_addr_i = 16'h0010;
    step(eh, eb);
    host_req_i = 0;
    step(eh, eb);

    // Saturation after 12 starved cycles, then clear coinciding with ack
    host_req_i = 1; host_addr_i = 16'h0030;
    vgen_sel_i = 1;
    for (int i = 0; i < 12; i++) step(eh, eb);
    vgen_sel_i = 0;
    step(eh, eb);
    host_req_i = 0;
    step(eh, eb);
    chk("stall_host_sat", 32'(stall_host_o), CAP);
    host_req_i = 1;
    vgen_sel_i = 1;
    for (int i = 0; i < 3; i++) step(eh, eb);
    vgen_sel_i = 0; clear_stats_i = 1;
    step(eh, eb);
    clear_stats_i = 0; host_req_i = 0;
    step(eh, eb);
    chk("stall_host_clr", 32'(stall_host_o), 0);

    // Read granted just before reset: its rd_valid is suppressed
    host_req_i = 1; host_addr_i = 16'h0040;
    step(eh, eb);
    host_req_i = 0; reset_i = 1;
    step(eh, eb);
    reset_i = 0;
    chk("rst_stall_host", 32'(stall_host_o), 0);
    chk("rst_stall_blit", 32'(stall_blit_o), 0);
    host_req_i = 1; blit_req_i = 1; host_addr_i = 16'h0041; blit_addr_i = 16'h0042;
    step(eh, eb);
    chk("rst_rr_host_first", d_hack, 1);
    host_req_i = 0;
    step(eh, eb);
    blit_req_i = 0;
    step(eh, eb);

    // Randomized traffic
    ha = 0; ba = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!ha && $urandom_range(0, 99) < 45) begin
        ha = 1; host_wr_i = 1'($urandom);
        host_addr_i = 16'($urandom_range(0, 31)); host_data_i = 16'($urandom);
      end
      if (!ba && $urandom_range(0, 99) < 45) begin
        ba = 1; blit_wr_i = 1'($urandom);
        blit_addr_i = 16'($urandom_range(0, 31)); blit_data_i = 16'($urandom);
      end
      host_req_i    = ha;
      blit_req_i    = ba;
      vgen_sel_i    = ($urandom_range(0, 99) < 25);
      vgen_addr_i   = 16'($urandom);
      clear_stats_i = ($urandom_range(0, 99) < 3);
      reset_i       = ($urandom_range(0, 199) == 0);
      step(eh, eb);
      if (eh) ha = 0;
      if (eb) ba = 0;
    end

    idle_inputs();
    reset_i = 0;
    for (int i = 0; i < 3; i++) step(eh, eb);
    chk("rd_queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
